// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by the sequencer top and its perf counters.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } hz_state_e;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

endpackage

// File: rtl/hz_perf_cnt.sv
// Wrapping event counter with synchronous active-low clear.
// Used for the stall, flush and timeout performance counts.
module hz_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: MEM wait > mispredict > load-use.
// Also keeps stall, flush and timeout perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_rs1_id,
  input  logic [REG_ADDR_W-1:0] i_rs2_id,
  input  logic                  i_rs1_used_id,
  input  logic                  i_rs2_used_id,
  input  logic [REG_ADDR_W-1:0] i_rd_ex,
  input  logic                  i_memrd_ex,
  input  logic                  i_regWEn_ex,
  input  logic                  i_instvld_ex,
  input  logic                  i_mispred_ex,
  input  logic                  i_mem_req,
  input  logic                  i_mem_ack,
  output logic                  o_stall_pc,
  output logic                  o_stall_ifid,
  output logic                  o_flush_ifid,
  output logic                  o_stall_idex,
  output logic                  o_flush_idex,
  output logic                  o_stall_exmem,
  output logic                  o_flush_memwb,
  output logic                  o_mem_timeout,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt,
  output logic [CNT_W-1:0]      o_tmo_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  hz_state_e         state_q;
  hz_state_e         state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              tmo_d;
  logic              flush_inc;
  logic              tmo_inc;
  logic              lu;
  logic              mem_hold;

  assign lu = i_instvld_ex & i_memrd_ex & i_regWEn_ex
            & (i_rd_ex != X0)
            & ((i_rs1_used_id & (i_rs1_id == i_rd_ex))
             | (i_rs2_used_id & (i_rs2_id == i_rd_ex)));

  assign mem_hold = i_mem_req & ~i_mem_ack;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    tmo_d         = 1'b0;
    flush_inc     = 1'b0;
    tmo_inc       = 1'b0;
    o_stall_pc    = 1'b0;
    o_stall_ifid  = 1'b0;
    o_flush_ifid  = 1'b0;
    o_stall_idex  = 1'b0;
    o_flush_idex  = 1'b0;
    o_stall_exmem = 1'b0;
    o_flush_memwb = 1'b0;
    o_busy        = 1'b0;
    if (!i_reset) begin
      o_flush_ifid  = 1'b1;
      o_flush_idex  = 1'b1;
      o_flush_memwb = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_hold) begin
            o_stall_pc    = 1'b1;
            o_stall_ifid  = 1'b1;
            o_stall_idex  = 1'b1;
            o_stall_exmem = 1'b1;
            o_flush_memwb = 1'b1;
            state_d       = MEM_WAIT;
            wait_d        = WAIT_W'(1);
          end else if (i_mispred_ex) begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
            flush_inc    = 1'b1;
          end else if (lu) begin
            o_stall_pc   = 1'b1;
            o_stall_ifid = 1'b1;
            o_flush_idex = 1'b1;
          end
        end
        MEM_WAIT: begin
          o_stall_pc    = 1'b1;
          o_stall_ifid  = 1'b1;
          o_stall_idex  = 1'b1;
          o_stall_exmem = 1'b1;
          o_flush_memwb = 1'b1;
          o_busy        = 1'b1;
          wait_d        = wait_q + WAIT_W'(1);
          if (i_mem_ack) begin
            state_d = RUN;
          end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = RUN;
            tmo_d   = 1'b1;
            tmo_inc = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q       <= RUN;
      wait_q        <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      o_mem_timeout <= tmo_d;
    end
  end

  hz_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (i_clk),
    .clr_n (i_reset),
    .inc   (o_stall_pc),
    .cnt   (o_stall_cnt)
  );

  hz_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (i_clk),
    .clr_n (i_reset),
    .inc   (flush_inc),
    .cnt   (o_flush_cnt)
  );

  hz_perf_cnt #(.CNT_W(CNT_W)) u_tmo_cnt (
    .clk   (i_clk),
    .clr_n (i_reset),
    .inc   (tmo_inc),
    .cnt   (o_tmo_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: RUN-state vector
// table plus hand sequences for MEM wait, timeout and reset.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 8;
  localparam int CW  = 32;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [4:0]    i_rs1_id, i_rs2_id, i_rd_ex;
  logic          i_rs1_used_id, i_rs2_used_id;
  logic          i_memrd_ex, i_regWEn_ex, i_instvld_ex;
  logic          i_mispred_ex, i_mem_req, i_mem_ack;
  logic          o_stall_pc, o_stall_ifid, o_flush_ifid;
  logic          o_stall_idex, o_flush_idex, o_stall_exmem;
  logic          o_flush_memwb, o_mem_timeout, o_busy;
  logic [CW-1:0] o_stall_cnt, o_flush_cnt, o_tmo_cnt;
  logic [6:0]    ctl;

  int n_chk  = 0;
  int n_fail = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rs1_id      (i_rs1_id),
    .i_rs2_id      (i_rs2_id),
    .i_rs1_used_id (i_rs1_used_id),
    .i_rs2_used_id (i_rs2_used_id),
    .i_rd_ex       (i_rd_ex),
    .i_memrd_ex    (i_memrd_ex),
    .i_regWEn_ex   (i_regWEn_ex),
    .i_instvld_ex  (i_instvld_ex),
    .i_mispred_ex  (i_mispred_ex),
    .i_mem_req     (i_mem_req),
    .i_mem_ack     (i_mem_ack),
    .o_stall_pc    (o_stall_pc),
    .o_stall_ifid  (o_stall_ifid),
    .o_flush_ifid  (o_flush_ifid),
    .o_stall_idex  (o_stall_idex),
    .o_flush_idex  (o_flush_idex),
    .o_stall_exmem (o_stall_exmem),
    .o_flush_memwb (o_flush_memwb),
    .o_mem_timeout (o_mem_timeout),
    .o_busy        (o_busy),
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt),
    .o_tmo_cnt     (o_tmo_cnt)
  );

  always #5 i_clk = ~i_clk;

  // {stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex, stall_exmem, flush_memwb}
  assign ctl = {o_stall_pc, o_stall_ifid, o_flush_ifid, o_stall_idex,
                o_flush_idex, o_stall_exmem, o_flush_memwb};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_MIS  = 7'b0010100;
  localparam logic [6:0] C_MEM  = 7'b1101011;
  localparam logic [6:0] C_RST  = 7'b0010101;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, memrd, wen, vld, mis, req, ack;
    logic [6:0] exp;
  } vec_t;

  vec_t tv[12];

  function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic u1, logic u2,
                              logic memrd, logic wen, logic vld,
                              logic mis, logic req, logic ack,
                              logic [6:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.u1 = u1; v.u2 = u2; v.memrd = memrd; v.wen = wen;
    v.vld = vld; v.mis = mis; v.req = req; v.ack = ack;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    i_rs1_id = v.rs1; i_rs2_id = v.rs2; i_rd_ex = v.rd;
    i_rs1_used_id = v.u1; i_rs2_used_id = v.u2;
    i_memrd_ex = v.memrd; i_regWEn_ex = v.wen;
    i_instvld_ex = v.vld; i_mispred_ex = v.mis;
    i_mem_req = v.req; i_mem_ack = v.ack;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE));
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    step();
    i_reset = 1'b1;
  endtask

  int exp_stall;
  int exp_flush;
  int tmo_pulses;

  initial begin
    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE);
    tv[1]  = mk(5, 0, 5, 1, 0, 1, 1, 1, 0, 0, 0, C_LU);
    tv[2]  = mk(1, 7, 7, 0, 1, 1, 1, 1, 0, 0, 0, C_LU);
    tv[3]  = mk(0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, C_NONE);
    tv[4]  = mk(5, 0, 5, 0, 0, 1, 1, 1, 0, 0, 0, C_NONE);
    tv[5]  = mk(5, 0, 5, 1, 0, 0, 1, 1, 0, 0, 0, C_NONE);
    tv[6]  = mk(5, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0, C_NONE);
    tv[7]  = mk(5, 0, 5, 1, 0, 1, 0, 1, 0, 0, 0, C_NONE);
    tv[8]  = mk(5, 0, 5, 1, 0, 1, 1, 1, 1, 0, 0, C_MIS);
    tv[9]  = mk(3, 4, 9, 1, 1, 0, 1, 1, 1, 0, 0, C_MIS);
    tv[10] = mk(5, 0, 5, 1, 0, 1, 1, 1, 0, 1, 1, C_LU);
    tv[11] = mk(5, 0, 5, 1, 0, 1, 1, 1, 1, 1, 1, C_MIS);

    // reset state
    i_reset = 1'b0;
    idle();
    @(negedge i_clk);
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_busy", 32'(o_busy), 0);
    step();
    chk("rst_stall_cnt", o_stall_cnt, 0);
    chk("rst_tmo", 32'(o_mem_timeout), 0);
    i_reset = 1'b1;

    // RUN-state vector table
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 12; i++) begin
      apply(tv[i]);
      @(negedge i_clk);
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(tv[i].exp));
      chk($sformatf("vec%0d_busy", i), 32'(o_busy), 0);
      if (tv[i].exp[6]) exp_stall++;
      if (tv[i].exp[4] && !tv[i].exp[6]) exp_flush++;
      step();
    end
    idle();
    @(negedge i_clk);
    chk("post_tbl_ctl", 32'(ctl), 32'(C_NONE));
    chk("tbl_stall_cnt", o_stall_cnt, 32'(exp_stall));
    chk("tbl_flush_cnt", o_flush_cnt, 32'(exp_flush));
    chk("tbl_tmo_cnt", o_tmo_cnt, 0);
    step();

    // peripheral wait, ack on 4th cycle, mispredict deferred
    do_reset();
    idle();
    i_mispred_ex = 1'b1;
    i_mem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      i_mem_ack = (c == 3);
      @(negedge i_clk);
      chk($sformatf("wait%0d_ctl", c), 32'(ctl), 32'(C_MEM));
      chk($sformatf("wait%0d_busy", c), 32'(o_busy), 32'(c > 0));
      step();
    end
    i_mem_req = 1'b0;
    i_mem_ack = 1'b0;
    @(negedge i_clk);
    chk("wait_defer_ctl", 32'(ctl), 32'(C_MIS));
    chk("wait_defer_busy", 32'(o_busy), 0);
    chk("wait_stall_cnt", o_stall_cnt, 4);
    chk("wait_flush_cnt0", o_flush_cnt, 0);
    step();
    idle();
    chk("wait_flush_cnt1", o_flush_cnt, 1);

    // timeout: 8 MEM_WAIT cycles then forced release
    do_reset();
    idle();
    i_mem_req = 1'b1;
    tmo_pulses = 0;
    for (int c = 0; c < 11; c++) begin
      if (c == 9) i_mem_req = 1'b0;
      @(negedge i_clk);
      if (o_mem_timeout) tmo_pulses++;
      if (c <= 8) begin
        chk($sformatf("tmo%0d_ctl", c), 32'(ctl), 32'(C_MEM));
        chk($sformatf("tmo%0d_busy", c), 32'(o_busy), 32'(c > 0));
      end else begin
        chk($sformatf("tmo%0d_ctl", c), 32'(ctl), 32'(C_NONE));
        chk($sformatf("tmo%0d_busy", c), 32'(o_busy), 0);
      end
      if (c == 9) chk("tmo_pulse_c9", 32'(o_mem_timeout), 1);
      step();
    end
    chk("tmo_pulses", 32'(tmo_pulses), 1);
    chk("tmo_cnt", o_tmo_cnt, 1);
    chk("tmo_stall_cnt", o_stall_cnt, 9);

    // reset asserted during MEM_WAIT cycle 2
    do_reset();
    idle();
    i_mem_req = 1'b1;
    step();
    step();
    @(negedge i_clk);
    chk("mid_busy_pre", 32'(o_busy), 1);
    i_reset = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'(ctl), 32'(C_RST));
    chk("mid_rst_busy", 32'(o_busy), 0);
    step();
    i_reset = 1'b1;
    i_mem_req = 1'b0;
    @(negedge i_clk);
    chk("mid_after_busy", 32'(o_busy), 0);
    chk("mid_after_ctl", 32'(ctl), 32'(C_NONE));
    chk("mid_after_stall_cnt", o_stall_cnt, 0);
    chk("mid_after_tmo_cnt", o_tmo_cnt, 0);
    tmo_pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (o_mem_timeout) tmo_pulses++;
    end
    chk("mid_no_tmo", 32'(tmo_pulses), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
